// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the M-stage data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_e;

  // Flags accesses that must not reach the SRAM; size 2'b11 is always illegal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge of right-justified store data into an existing word.
module store_merge
  import dmem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_byte_off,
  output logic [31:0] o_merged
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_merged and no latch is inferred.
    o_merged = i_old_word;
    case (i_size)
      SZ_B:    o_merged[{i_byte_off, 3'b000} +: 8]    = i_wdata[7:0];
      SZ_H:    o_merged[{i_byte_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      SZ_W:    o_merged = i_wdata;
      default: o_merged = i_old_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder for a byte-enable-less word SRAM;
// sub-word stores go through read-modify-write.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic [31:0]       w_merged;

  // Address bits above the SRAM window alias and are deliberately ignored.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  store_merge u_store_merge (
    .i_old_word (mem_rdata),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_byte_off (r_addr[1:0]),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_buf        <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_addr       <= req_addr[ADDR_W+1:0];
            r_wdata      <= req_wdata;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              r_resp_err <= 1'b1;
              r_state    <= RESP;
            end else if (req_we && req_size == SZ_W) begin
              r_buf   <= req_wdata;
              r_state <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: r_state <= CAP;
        CAP: begin
          if (r_we) begin
            r_buf   <= w_merged;
            r_state <= WR;
          end else begin
            r_resp_rdata <= mem_rdata;
            r_state      <= RESP;
          end
        end
        WR: r_state <= RESP;
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // SRAM strobes and handshakes decode from state alone, never from req_*.
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_en     = (r_state == RD) || (r_state == WR);
  assign mem_we     = (r_state == WR);
  assign mem_addr   = r_addr[ADDR_W+1:2];
  assign mem_wdata  = r_buf;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an SRAM model and a response scoreboard.
module tb_dmem_responder;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_mem_wr = 0;

  logic [31:0] sram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port SRAM: read data appears the cycle after the read.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en && mem_we) n_mem_wr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got rdata %h err %0b expected none", resp_rdata, resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  // Issues one request from IDLE (posedge+1) and returns at posedge+1 back in IDLE.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_rd, input int exp_wr,
                        input int exp_wr_cyc, input logic [31:0] exp_wr_addr,
                        input logic [31:0] exp_wr_data, input int hold);
    int          lat = 0;
    int          n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, held = '0;
    logic        ready_seen = 1'b0;
    check({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    resp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (req_ready) ready_seen = 1'b1;
      if (mem_en && !mem_we) begin n_rd++; if (rd_cyc == 0) rd_cyc = c; end
      if (mem_en && mem_we) begin
        n_wr++; if (wr_cyc == 0) wr_cyc = c;
        wr_addr = 32'(mem_addr); wr_data = mem_wdata;
      end
      if (resp_valid) begin lat = c; break; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_req_ready"}, {31'd0, ready_seen}, 32'd0);
    check({tag, "_reads"}, n_rd, exp_rd);
    check({tag, "_writes"}, n_wr, exp_wr);
    if (exp_rd > 0) check({tag, "_read_cycle"}, rd_cyc, 1);
    if (exp_wr > 0) begin
      check({tag, "_write_cycle"}, wr_cyc, exp_wr_cyc);
      check({tag, "_write_addr"}, wr_addr, exp_wr_addr);
      check({tag, "_write_data"}, wr_data, exp_wr_data);
    end
    if (lat == 0) begin
      $display("FAIL %s_timeout: got no response expected one within 20 cycles", tag);
      exp_q.delete();
      resp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      held = resp_rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_hold_rdata"}, resp_rdata, held);
        check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_hold_mem_en"}, {31'd0, mem_en}, 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 check({tag, "_idle_after_hs"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int wr0;
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= 32'd0;
    sram[4] <= 32'hAABBCCDD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //      tag     we    size   addr   wdata          rdata          err  lat rd wr wcyc waddr  wdata          hold
    do_req("lw10",  1'b0, 2'b10, 32'h10, 32'h0,        32'hAABBCCDD, 1'b0, 3, 1, 0, 0, 32'd0, 32'h0,        0);
    do_req("sb13",  1'b1, 2'b00, 32'h13, 32'h11223344, 32'h0,        1'b0, 4, 1, 1, 3, 32'd4, 32'h44BBCCDD, 0);
    do_req("lw10b", 1'b0, 2'b10, 32'h10, 32'h0,        32'h44BBCCDD, 1'b0, 3, 1, 0, 0, 32'd0, 32'h0,        0);
    sram[4] <= 32'hAABBCCDD;
    do_req("sh12",  1'b1, 2'b01, 32'h12, 32'h00005566, 32'h0,        1'b0, 4, 1, 1, 3, 32'd4, 32'h5566CCDD, 0);
    do_req("sb10",  1'b1, 2'b00, 32'h10, 32'hFFFFFF77, 32'h0,        1'b0, 4, 1, 1, 3, 32'd4, 32'h5566CC77, 0);
    do_req("sw14",  1'b1, 2'b10, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 1, 32'd5, 32'hDEADBEEF, 0);
    do_req("lw12",  1'b0, 2'b10, 32'h12, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 32'd0, 32'h0,        0);
    do_req("sh11",  1'b1, 2'b01, 32'h11, 32'h1234,     32'h0,        1'b1, 1, 0, 0, 0, 32'd0, 32'h0,        0);
    do_req("sz11",  1'b0, 2'b11, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0, 32'd0, 32'h0,        0);
    do_req("lw14bp",1'b0, 2'b10, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 0, 32'd0, 32'h0,        5);

    // Reset while an SB to 0x13 sits in CAP: the write must never be issued.
    sram[4] <= 32'hAABBCCDD;
    wr0 = n_mem_wr;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h13; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstcap_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstcap_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstcap_resp_err", {31'd0, resp_err}, 32'd0);
    check("rstcap_resp_rdata", resp_rdata, 32'd0);
    check("rstcap_mem_en", {31'd0, mem_en}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rstcap_no_write", n_mem_wr - wr0, 0);
    check("rstcap_sram_word", sram[4], 32'hAABBCCDD);
    do_req("lw10c", 1'b0, 2'b10, 32'h10, 32'h0,        32'hAABBCCDD, 1'b0, 3, 1, 0, 0, 32'd0, 32'h0,        0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
